// File: rtl/spi_txn_sequencer_pkg.sv
// Shared definitions for the SPI memory-slave transaction sequencer.
//   - default address / data widths
//   - command-byte field positions: {addr[ADDR_W-1:0], rw}
//   - state encodings (also the value shown on the debug LEDs)
package spi_txn_sequencer_pkg;

   localparam int ADDR_W_DEF   = 7;
   localparam int DATA_W_DEF   = 8;

   localparam int CMD_RW_POS   = 0;
   localparam int CMD_ADDR_LSB = 1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_CMD       = 3'd1;
   localparam state_t ST_LATCH     = 3'd2;
   localparam state_t ST_RD_WAIT   = 3'd3;
   localparam state_t ST_RD_LOAD   = 3'd4;
   localparam state_t ST_RD_SHIFT  = 3'd5;
   localparam state_t ST_WR_SHIFT  = 3'd6;
   localparam state_t ST_WR_COMMIT = 3'd7;

   // Builds a command byte with the default field layout.
   function automatic logic [DATA_W_DEF-1:0] cmd_byte(input logic [ADDR_W_DEF-1:0] addr,
                                                      input logic                  rw);
      return {addr, rw};
   endfunction

endpackage

// File: rtl/spi_txn_sequencer.sv
// Transaction sequencer for the SPI memory slave.
// Consumes the conditioned chip select and single-clk SCLK edge pulses and
// produces the strobes that drive the shift register, address latch, data
// memory and MISO buffer. Bursts are supported by pulsing addr_inc after
// every data byte; the address latch does the wrap.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   cs_n       conditioned chip select, active low
//   sclk_rise  one-clk pulse per SCLK rising edge (MOSI sample)
//   sclk_fall  one-clk pulse per SCLK falling edge (MISO update)
//   rw_bit     shift register bit 0 (1 = read, 0 = write)
//   addr_we    address latch capture strobe
//   addr_inc   address latch increment strobe
//   dm_we      data memory write strobe
//   sr_load    shift register parallel-load strobe
//   miso_en    MISO buffer enable
//   state_dbg  current state encoding for the LEDs
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE      0 | waiting for cs_n low (after reset: high first, then low)
// CMD       1 | shifting in the command byte on sclk_rise
// LATCH     2 | address latch captures, branch on rw_bit
// RD_WAIT   3 | one clk of data memory read latency
// RD_LOAD   4 | shift register loads the read byte
// RD_SHIFT  5 | MISO driven, byte shifted out on sclk_fall
// WR_SHIFT  6 | data byte shifted in on sclk_rise
// WR_COMMIT 7 | data memory write and address increment
module spi_txn_sequencer
   import spi_txn_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cs_n,
   input  logic       sclk_rise,
   input  logic       sclk_fall,
   input  logic       rw_bit,
   output logic       addr_we,
   output logic       addr_inc,
   output logic       dm_we,
   output logic       sr_load,
   output logic       miso_en,
   output logic [2:0] state_dbg
);

   localparam int CNT_W = $clog2(DATA_W);
   // The command byte is {addr, rw}, i.e. ADDR_W+1 bits.
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q;
   logic             rd_done;
   logic             addr_we_q, addr_inc_q, dm_we_q, sr_load_q, miso_en_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_done = 1'b0;
      // Deselect wins over everything, including a byte-completing edge.
      if ((state_q != ST_IDLE) && cs_n) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!cs_n && armed_q) begin
                  state_d = ST_CMD;
                  cnt_d   = '0;
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  if (cnt_q == CMD_LAST) begin
                     state_d = ST_LATCH;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            ST_LATCH: begin
               state_d = rw_bit ? ST_RD_WAIT : ST_WR_SHIFT;
               cnt_d   = '0;
            end
            ST_RD_WAIT: state_d = ST_RD_LOAD;
            ST_RD_LOAD: state_d = ST_RD_SHIFT;
            ST_RD_SHIFT: begin
               if (sclk_fall) begin
                  if (cnt_q == DATA_LAST) begin
                     state_d = ST_RD_WAIT;
                     cnt_d   = '0;
                     rd_done = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            ST_WR_SHIFT: begin
               if (sclk_rise) begin
                  if (cnt_q == DATA_LAST) begin
                     state_d = ST_WR_COMMIT;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            ST_WR_COMMIT: begin
               state_d = ST_WR_SHIFT;
               cnt_d   = '0;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Strobes are registered from the next state so they line up with the
   // state they belong to and never glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         armed_q    <= 1'b0;
         addr_we_q  <= 1'b0;
         addr_inc_q <= 1'b0;
         dm_we_q    <= 1'b0;
         sr_load_q  <= 1'b0;
         miso_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         // A fresh transaction needs cs_n seen high at least once after reset.
         armed_q    <= armed_q | cs_n;
         addr_we_q  <= (state_d == ST_LATCH);
         addr_inc_q <= rd_done | (state_d == ST_WR_COMMIT);
         dm_we_q    <= (state_d == ST_WR_COMMIT);
         sr_load_q  <= (state_d == ST_RD_LOAD);
         miso_en_q  <= (state_d == ST_RD_SHIFT);
      end
   end

   assign addr_we   = addr_we_q;
   assign addr_inc  = addr_inc_q;
   assign dm_we     = dm_we_q;
   assign sr_load   = sr_load_q;
   assign miso_en   = miso_en_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Self-checking bench for spi_txn_sequencer. A small model of the shift
// register, address latch and data memory reacts to the DUT strobes; a
// monitor records every strobe and the directed sequence compares them
// against the events it queued when driving the stimulus.
module tb_spi_txn_sequencer;
   import spi_txn_sequencer_pkg::*;

   localparam int K_AWE  = 1;
   localparam int K_DWE  = 2;
   localparam int K_AINC = 3;
   localparam int K_LOAD = 4;

   typedef struct packed {
      logic [7:0] kind;
      logic [6:0] addr;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cs_n = 1'b1;
   logic       sclk_rise = 1'b0;
   logic       sclk_fall = 1'b0;
   logic       rw_bit = 1'b0;
   logic       mosi = 1'b0;
   logic       in_write = 1'b0;
   logic       addr_we, addr_inc, dm_we, sr_load, miso_en;
   logic [2:0] state_dbg;

   int n_checks = 0;
   int n_fail = 0;

   spi_txn_sequencer #(.ADDR_W(7), .DATA_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cs_n      (cs_n),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .rw_bit    (rw_bit),
      .addr_we   (addr_we),
      .addr_inc  (addr_inc),
      .dm_we     (dm_we),
      .sr_load   (sr_load),
      .miso_en   (miso_en),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // Environment: shift register, address latch, data memory.
   logic [7:0] env_sr;
   logic [6:0] env_addr;
   logic [7:0] env_mem [128];

   always @(posedge clk) begin
      if (!reset_n) begin
         env_sr   <= 8'h00;
         env_addr <= 7'h00;
         for (int i = 0; i < 128; i++) env_mem[i] <= 8'(i) ^ 8'h5A;
      end else begin
         if (sr_load) env_sr <= env_mem[env_addr];
         else if (sclk_rise) env_sr <= {env_sr[6:0], mosi};
         if (addr_we) env_addr <= env_sr[7:1];
         else if (addr_inc) env_addr <= env_addr + 7'd1;
         if (dm_we) env_mem[env_addr] <= env_sr;
      end
   end

   function automatic ev_t mk_ev(input int k, input logic [6:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = 8'(k);
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  miso_wr_bad = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (addr_we)  obs_q.push_back(mk_ev(K_AWE, env_sr[7:1], 8'h00));
         if (dm_we)    obs_q.push_back(mk_ev(K_DWE, env_addr, env_sr));
         if (addr_inc) obs_q.push_back(mk_ev(K_AINC, env_addr, 8'h00));
         if (sr_load)  obs_q.push_back(mk_ev(K_LOAD, env_addr, 8'h00));
         if (in_write && (miso_en !== 1'b0)) miso_wr_bad++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, observed no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input int k, input logic [6:0] a, input logic [7:0] d);
      exp_q.push_back(mk_ev(k, a, d));
   endtask

   task automatic drain(output int n_ev, output int n_load, output int n_inc);
      ev_t o, e;
      n_ev = 0; n_load = 0; n_inc = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_ev++;
         if (o.kind == 8'(K_LOAD)) n_load++;
         if (o.kind == 8'(K_AINC)) n_inc++;
         n_checks++;
         assert (exp_q.size() > 0)
         else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed kind %0d addr %0h, expected no strobe", o.kind, o.addr);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_event", 32'(o), 32'(e));
         end
      end
      chk("sb_missing", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic pulse_rise();
      @(negedge clk) sclk_rise = 1'b1;
      @(negedge clk) sclk_rise = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_fall();
      @(negedge clk) sclk_fall = 1'b1;
      @(negedge clk) sclk_fall = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b);
      mosi = b;
      pulse_fall();
      pulse_rise();
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 7; i > 7 - n; i--) spi_bit(v[i]);
   endtask

   initial begin
      int n_ev, n_load, n_inc, base;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_reset", 32'({addr_we, addr_inc, dm_we, sr_load, miso_en, state_dbg}), 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_after_release", 32'({addr_we, addr_inc, dm_we, sr_load, miso_en, state_dbg}), 32'h0);

      // Write: command 0x54 (addr 0x2A, rw 0), data 0xC3
      in_write = 1'b1;
      base = miso_wr_bad;
      rw_bit = 1'b0;
      expect_ev(K_AWE, 7'h2A, 8'h00);
      expect_ev(K_DWE, 7'h2A, 8'hC3);
      expect_ev(K_AINC, 7'h2A, 8'h00);
      @(negedge clk) cs_n = 1'b0;
      @(negedge clk);
      chk("wr_cmd_state", 32'(state_dbg), 32'(ST_CMD));
      send_bits(cmd_byte(7'h2A, 1'b0), 8);
      chk("wr_shift_state", 32'(state_dbg), 32'(ST_WR_SHIFT));
      send_bits(8'hC3, 7);
      mosi = 1'b1;
      pulse_fall();
      @(negedge clk) sclk_rise = 1'b1;
      @(negedge clk) sclk_rise = 1'b0;
      chk("wr_dm_we_latency", 32'(dm_we), 32'h1);
      chk("wr_addr_inc", 32'(addr_inc), 32'h1);
      chk("wr_commit_state", 32'(state_dbg), 32'(ST_WR_COMMIT));
      @(negedge clk);
      chk("wr_dm_we_single", 32'(dm_we), 32'h0);
      chk("wr_back_to_shift", 32'(state_dbg), 32'(ST_WR_SHIFT));
      @(negedge clk) cs_n = 1'b1;
      @(negedge clk);
      chk("wr_idle", 32'(state_dbg), 32'(ST_IDLE));
      in_write = 1'b0;
      drain(n_ev, n_load, n_inc);
      chk("wr_mem", 32'(env_mem[7'h2A]), 32'hC3);
      chk("wr_miso_off", 32'(miso_wr_bad - base), 32'h0);

      // Burst read: command 0xFF (addr 0x7F, rw 1), three bytes, wrap
      repeat (2) @(negedge clk);
      rw_bit = 1'b1;
      expect_ev(K_AWE, 7'h7F, 8'h00);
      expect_ev(K_LOAD, 7'h7F, 8'h00);
      expect_ev(K_AINC, 7'h7F, 8'h00);
      expect_ev(K_LOAD, 7'h00, 8'h00);
      expect_ev(K_AINC, 7'h00, 8'h00);
      expect_ev(K_LOAD, 7'h01, 8'h00);
      expect_ev(K_AINC, 7'h01, 8'h00);
      @(negedge clk) cs_n = 1'b0;
      send_bits(8'hFF, 7);
      mosi = 1'b1;
      pulse_fall();
      @(negedge clk) sclk_rise = 1'b1;
      @(negedge clk) sclk_rise = 1'b0;
      chk("rd_addr_we_p1", 32'(addr_we), 32'h1);
      chk("rd_latch_state", 32'(state_dbg), 32'(ST_LATCH));
      @(negedge clk);
      chk("rd_wait_p2", 32'(state_dbg), 32'(ST_RD_WAIT));
      chk("rd_wait_quiet", 32'({addr_we, sr_load, miso_en, dm_we}), 32'h0);
      @(negedge clk);
      chk("rd_sr_load_p3", 32'(sr_load), 32'h1);
      chk("rd_miso_off_p3", 32'(miso_en), 32'h0);
      @(negedge clk);
      chk("rd_miso_on_p4", 32'(miso_en), 32'h1);
      chk("rd_shift_state", 32'(state_dbg), 32'(ST_RD_SHIFT));
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 8; i++) begin
            mosi = 1'b0;
            if (b == 2 && i == 7) begin
               @(negedge clk) sclk_fall = 1'b1;
               @(negedge clk) begin sclk_fall = 1'b0; cs_n = 1'b1; end
            end else begin
               pulse_fall();
               pulse_rise();
            end
         end
      end
      @(negedge clk);
      chk("rd_idle", 32'(state_dbg), 32'(ST_IDLE));
      chk("rd_miso_idle", 32'(miso_en), 32'h0);
      drain(n_ev, n_load, n_inc);
      chk("rd_load_count", n_load, 3);
      chk("rd_inc_count", n_inc, 3);

      // miso_en drop after deselect in RD_SHIFT
      repeat (2) @(negedge clk);
      rw_bit = 1'b1;
      expect_ev(K_AWE, 7'h01, 8'h00);
      expect_ev(K_LOAD, 7'h01, 8'h00);
      @(negedge clk) cs_n = 1'b0;
      send_bits(cmd_byte(7'h01, 1'b1), 8);
      @(negedge clk);
      chk("miso_shift_state", 32'(state_dbg), 32'(ST_RD_SHIFT));
      pulse_fall();
      pulse_fall();
      @(negedge clk) cs_n = 1'b1;
      chk("miso_before_csn", 32'(miso_en), 32'h1);
      @(negedge clk);
      chk("miso_drop", 32'(miso_en), 32'h0);
      chk("miso_idle", 32'(state_dbg), 32'(ST_IDLE));
      drain(n_ev, n_load, n_inc);

      // Abort after 5 data bits of a write
      repeat (2) @(negedge clk);
      rw_bit = 1'b0;
      in_write = 1'b1;
      base = miso_wr_bad;
      expect_ev(K_AWE, 7'h08, 8'h00);
      @(negedge clk) cs_n = 1'b0;
      send_bits(cmd_byte(7'h08, 1'b0), 8);
      send_bits(8'hFF, 5);
      @(negedge clk) cs_n = 1'b1;
      @(negedge clk);
      chk("abort_idle", 32'(state_dbg), 32'(ST_IDLE));
      chk("abort_no_strobe", 32'({dm_we, addr_inc}), 32'h0);
      repeat (4) @(negedge clk);
      in_write = 1'b0;
      drain(n_ev, n_load, n_inc);
      chk("abort_mem", 32'(env_mem[7'h08]), 32'h52);
      chk("abort_miso_off", 32'(miso_wr_bad - base), 32'h0);

      // Collision: cs_n high together with the 8th command rise
      repeat (2) @(negedge clk);
      rw_bit = 1'b0;
      @(negedge clk) cs_n = 1'b0;
      send_bits(8'h54, 7);
      mosi = 1'b0;
      pulse_fall();
      @(negedge clk) begin sclk_rise = 1'b1; cs_n = 1'b1; end
      @(negedge clk) sclk_rise = 1'b0;
      chk("coll_no_addr_we", 32'(addr_we), 32'h0);
      chk("coll_idle", 32'(state_dbg), 32'(ST_IDLE));
      repeat (4) @(negedge clk);
      drain(n_ev, n_load, n_inc);
      chk("coll_no_strobes", n_ev, 0);

      // Reset in the middle of RD_SHIFT
      repeat (2) @(negedge clk);
      rw_bit = 1'b1;
      expect_ev(K_AWE, 7'h02, 8'h00);
      expect_ev(K_LOAD, 7'h02, 8'h00);
      @(negedge clk) cs_n = 1'b0;
      send_bits(cmd_byte(7'h02, 1'b1), 8);
      @(negedge clk);
      chk("rst_mid_shift", 32'(state_dbg), 32'(ST_RD_SHIFT));
      pulse_fall();
      pulse_fall();
      drain(n_ev, n_load, n_inc);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("rst_async_outputs", 32'({addr_we, addr_inc, dm_we, sr_load, miso_en}), 32'h0);
      @(negedge clk) reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_needs_rearm", 32'(state_dbg), 32'(ST_IDLE));
      cs_n = 1'b1;
      @(negedge clk) cs_n = 1'b0;
      @(negedge clk);
      chk("rst_clean_cmd", 32'(state_dbg), 32'(ST_CMD));
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_final_idle", 32'(state_dbg), 32'(ST_IDLE));
      drain(n_ev, n_load, n_inc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Transaction sequencer for the SPI memory slave. It consumes the conditioned chip-select level and single-cycle SCLK edge pulses from the input conditioners. It drives the strobes that sequence the shift register, address latch, data memory and MISO tri-state buffer. It adds byte-burst support by auto-incrementing the latched address after every data byte, and exposes its state on the debug LEDs.

## Interface

Parameters:
- ADDR_W, 7, width of the memory address carried in the command byte (command byte = {addr[ADDR_W-1:0], rw}).
- DATA_W, 8, bits per SPI byte; bit counter width is clog2(DATA_W).

Ports:
- clk  input  1  FPGA clock; every register updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cs_n  input  1  conditioned chip select, active low.
- sclk_rise  input  1  one-clk pulse per SCLK rising edge (MOSI sample edge).
- sclk_fall  input  1  one-clk pulse per SCLK falling edge (MISO update edge).
- rw_bit  input  1  shift register parallel-out bit 0; 1 = read, 0 = write.
- addr_we  output  1  one-clk pulse; address latch captures the shift register's upper ADDR_W bits.
- addr_inc  output  1  one-clk pulse; address latch increments modulo 2^ADDR_W.
- dm_we  output  1  one-clk write strobe to data memory.
- sr_load  output  1  one-clk parallel-load strobe to the shift register.
- miso_en  output  1  MISO buffer enable.
- state_dbg  output  3  current state encoding, routed to leds[2:0].

## Operation

States (encoding 0-6): IDLE, CMD, LATCH, RD_WAIT, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT. WR_COMMIT uses encoding 7.

- IDLE: when cs_n = 0, go to CMD and clear bit_cnt.
- CMD: each sclk_rise increments bit_cnt. The rise that completes DATA_W bits goes to LATCH.
- LATCH: addr_we = 1 for exactly one clk. Next state is RD_WAIT if rw_bit = 1, otherwise WR_SHIFT. bit_cnt is cleared.
- RD_WAIT: one clk for data memory read latency. No outputs are asserted. Next state is RD_LOAD.
- RD_LOAD: sr_load = 1 for one clk. Next state is RD_SHIFT.
- RD_SHIFT: miso_en = 1. Each sclk_fall increments bit_cnt. The fall that completes DATA_W bits asserts addr_inc and goes to RD_WAIT, so the next byte is loaded (burst read).
- WR_SHIFT: each sclk_rise increments bit_cnt. The rise that completes DATA_W bits goes to WR_COMMIT.
- WR_COMMIT: dm_we = 1 and addr_inc = 1 for one clk. Next state is WR_SHIFT with bit_cnt cleared (burst write).
- cs_n = 1 in any non-IDLE state: next state is IDLE and all strobes are 0 that clk. A partial byte is discarded: no dm_we and no addr_inc.
- cs_n rising in the same clk as a byte-completing edge: cs_n wins. No addr_we, dm_we or addr_inc is issued.
- sclk pulses are ignored in IDLE, LATCH, RD_WAIT, RD_LOAD and WR_COMMIT. The SCLK period must be at least 8 clk, so no edge is lost.
- Address wrap: incrementing from 2^ADDR_W-1 wraps to 0. The wrap is implemented by the address latch; the sequencer only pulses addr_inc.

## Timing

- Reset value of every output is 0: addr_we, addr_inc, dm_we, sr_load, miso_en, and state_dbg = IDLE. bit_cnt resets to 0.
- Reset asserted mid-transaction returns the block to IDLE immediately and asynchronously. After release, a new transaction requires cs_n to be sampled high and then low.
- All outputs are registered Moore outputs, one clk after the triggering input pulse.
- Command to first MISO data: the 8th sclk_rise is followed by addr_we at +1 clk, RD_WAIT at +2, sr_load at +3, and miso_en = 1 from +4.
- Write commit: dm_we occurs 1 clk after the byte-completing sclk_rise.
- miso_en drops in the clk after cs_n is sampled high.

## Structure

- Shared package: state enum, the ADDR_W/DATA_W defaults, and the command-byte field positions (rw = bit 0, addr = bits [ADDR_W:1]).
- A single module containing a state register, next-state logic and bit_cnt. A separate sub-module is not warranted.
- Bit counter may be factored as spi_bit_counter (clear, inc, done at DATA_W).

## Test plan

- Reset mid-RD_SHIFT, then release: outputs all 0 and state_dbg = 0. The next cs_n low→high→low starts a clean CMD.
- Write: command 0x54 (addr 0x2A, rw 0) followed by byte 0xC3: addr_we once, then dm_we once 1 clk after the 16th rise, then addr_inc. Memory[0x2A] = 0xC3.
- Burst read: command 0xFF (addr 0x7F, rw 1) for 3 bytes: sr_load 3 times and addr_inc 3 times. Addresses read are 0x7F, 0x00, 0x01 (wrap).
- Abort: cs_n goes high after 5 data bits of a write: no dm_we, no addr_inc, and IDLE next clk.
- Collision: cs_n goes high in the same clk as the 8th command sclk_rise: no addr_we, and the state returns to IDLE.
- miso_en: 0 throughout a write transaction. During a read it is 1 only in RD_SHIFT and drops 1 clk after cs_n goes high.
